// File: rtl/pc_gen_pkg.sv
// Shared constants and state encoding for the PC generation stage.
package pc_gen_pkg;

  localparam int          PC_W     = 64;
  localparam logic [63:0] PC_START = 64'h8000_0000;
  localparam int          PC_STEP  = 4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1
  } pc_state_e;

endpackage

// File: rtl/pc_redir_arb.sv
// Combinational redirect select: a trap redirect beats a branch redirect.
module pc_redir_arb
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = PC_W
) (
  input  logic              i_br_redir,
  input  logic [ADDR_W-1:0] i_br_tgt,
  input  logic              i_trap_redir,
  input  logic [ADDR_W-1:0] i_trap_tgt,
  output logic              o_redir,
  output logic [ADDR_W-1:0] o_redir_tgt
);

  assign o_redir     = i_trap_redir | i_br_redir;
  assign o_redir_tgt = i_trap_redir ? i_trap_tgt : i_br_tgt;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: boot delay, sequential +4 stepping, branch/trap redirect.
// Optional macro PC_ALIGN_CHK_EN passes misaligned targets through and flags them.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = PC_W,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(PC_START),
  parameter int                BOOT_DELAY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready_i,
  input  logic              br_redir_i,
  input  logic [ADDR_W-1:0] br_tgt_i,
  input  logic              trap_redir_i,
  input  logic [ADDR_W-1:0] trap_tgt_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              brch_sel_o,
  output logic              misalign_o
);

  // valid_o/ready_i: a PC transfers on any edge where both are high; pc_o is
  // stable while valid_o=1 and ready_i=0 except when a redirect replaces it.

  localparam int CNT_W = (BOOT_DELAY > 0) ? $clog2(BOOT_DELAY + 1) : 1;

  pc_state_e         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic              r_brch;
  logic              r_mis;

  logic              w_redir;
  logic [ADDR_W-1:0] w_redir_tgt;
  logic [ADDR_W-1:0] w_load_tgt;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_fire;
  logic              w_tgt_mis;
  logic              w_step_mis;

  pc_redir_arb #(.ADDR_W(ADDR_W)) u_arb (
    .i_br_redir   (br_redir_i),
    .i_br_tgt     (br_tgt_i),
    .i_trap_redir (trap_redir_i),
    .i_trap_tgt   (trap_tgt_i),
    .o_redir      (w_redir),
    .o_redir_tgt  (w_redir_tgt)
  );

  assign w_fire    = r_valid & ready_i;
  assign w_pc_next = r_pc + ADDR_W'(PC_STEP);

`ifdef PC_ALIGN_CHK_EN
  assign w_load_tgt = w_redir_tgt;
  assign w_tgt_mis  = |w_redir_tgt[1:0];
  assign w_step_mis = |w_pc_next[1:0];
`else
  assign w_load_tgt = w_redir_tgt & ~ADDR_W'(3);
  assign w_tgt_mis  = 1'b0;
  assign w_step_mis = 1'b0;
`endif

  // A redirect overrides both the boot countdown and any sequential step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_cnt   <= CNT_W'(BOOT_DELAY);
      r_valid <= 1'b0;
      r_pc    <= START_ADDR;
      r_brch  <= 1'b0;
      r_mis   <= 1'b0;
    end else if (w_redir) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_valid <= 1'b1;
      r_pc    <= w_load_tgt;
      r_brch  <= 1'b1;
      r_mis   <= w_tgt_mis;
    end else begin
      case (r_state)
        ST_BOOT: begin
          if (r_cnt == '0) begin
            r_state <= ST_RUN;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (w_fire) begin
            r_pc   <= w_pc_next;
            r_brch <= 1'b0;
            r_mis  <= w_step_mis;
          end
        end
        default: begin
          r_state <= ST_BOOT;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign valid_o    = r_valid;
  assign pc_o       = r_pc;
  assign brch_sel_o = r_brch;
  assign misalign_o = r_mis;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with a cycle model and literal spot checks.
module tb_pc_gen;

  localparam int          AW    = 64;
  localparam logic [63:0] START = 64'h8000_0000;
  localparam int          BOOT  = 4;
`ifdef PC_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          ready_i;
  logic          br_redir_i;
  logic [AW-1:0] br_tgt_i;
  logic          trap_redir_i;
  logic [AW-1:0] trap_tgt_i;
  logic          valid_o;
  logic [AW-1:0] pc_o;
  logic          brch_sel_o;
  logic          misalign_o;

  int n_checks = 0;
  int n_pass   = 0;

  pc_gen #(.ADDR_W(AW), .START_ADDR(START), .BOOT_DELAY(BOOT)) dut (
    .clk          (clk),
    .reset        (reset),
    .ready_i      (ready_i),
    .br_redir_i   (br_redir_i),
    .br_tgt_i     (br_tgt_i),
    .trap_redir_i (trap_redir_i),
    .trap_tgt_i   (trap_tgt_i),
    .valid_o      (valid_o),
    .pc_o         (pc_o),
    .brch_sel_o   (brch_sel_o),
    .misalign_o   (misalign_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Tracks "cycles still to wait" and "is running" as plain integers; the
  // misalign flag is derived directly from the low bits of the model PC.
  bit          m_ok  = 1'b0;
  bit          m_run;
  int          m_wait;
  logic [63:0] m_pc;
  bit          m_tag;
  logic [63:0] m_t;
  logic [63:0] exp_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_run  = 1'b0;
      m_wait = BOOT;
      m_pc   = START;
      m_tag  = 1'b0;
      m_ok   = 1'b1;
      exp_q.delete();
    end else if (trap_redir_i || br_redir_i) begin
      m_t    = trap_redir_i ? trap_tgt_i : br_tgt_i;
      m_pc   = ALIGN ? m_t : m_t - (m_t % 4);
      m_run  = 1'b1;
      m_wait = 0;
      m_tag  = 1'b1;
    end else if (!m_run) begin
      if (m_wait == 0) m_run = 1'b1;
      else m_wait = m_wait - 1;
    end else if (ready_i) begin
      exp_q.push_back(m_pc);
      m_pc  = m_pc + 64'd4;
      m_tag = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  bit seen_300 = 1'b0;
  always @(negedge clk) begin
    if (m_ok) begin
      cmp("cmp_valid", {63'd0, valid_o}, {63'd0, m_run});
      cmp("cmp_pc", pc_o, m_pc);
      cmp("cmp_brch_sel", {63'd0, brch_sel_o}, {63'd0, m_tag});
      cmp("cmp_misalign", {63'd0, misalign_o}, {63'd0, (ALIGN && (m_pc % 4 != 0))});
      if (valid_o && pc_o == 64'h8000_0300) seen_300 = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic br(input logic [63:0] tgt);
    br_redir_i = 1'b1; br_tgt_i = tgt;
    tick();
    br_redir_i = 1'b0;
  endtask

  task automatic trap(input logic [63:0] tgt);
    trap_redir_i = 1'b1; trap_tgt_i = tgt;
    tick();
    trap_redir_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; ready_i = 1'b1;
    br_redir_i = 1'b0; br_tgt_i = '0;
    trap_redir_i = 1'b0; trap_tgt_i = '0;
    tick(); tick();
    cmp("rst_valid", {63'd0, valid_o}, 64'd0);
    cmp("rst_pc", pc_o, 64'h8000_0000);
    cmp("rst_brch", {63'd0, brch_sel_o}, 64'd0);
    cmp("rst_mis", {63'd0, misalign_o}, 64'd0);

    // Boot delay then sequential stepping
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cmp("boot_valid_low", {63'd0, valid_o}, 64'd0);
    end
    tick(); cmp("first_valid", {63'd0, valid_o}, 64'd1);
    cmp("first_pc", pc_o, 64'h8000_0000);
    tick(); cmp("seq_pc1", pc_o, 64'h8000_0004);
    tick(); cmp("seq_pc2", pc_o, 64'h8000_0008);

    // Backpressure
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("stall_pc", pc_o, 64'h8000_0008);
      cmp("stall_valid", {63'd0, valid_o}, 64'd1);
    end
    ready_i = 1'b1;
    tick(); cmp("resume_pc", pc_o, 64'h8000_000C);

    // Branch while stalled
    ready_i = 1'b0;
    br(64'h8000_0100);
    cmp("br_pc", pc_o, 64'h8000_0100);
    cmp("br_tag", {63'd0, brch_sel_o}, 64'd1);
    tick(); cmp("br_tag_hold", {63'd0, brch_sel_o}, 64'd1);
    ready_i = 1'b1;
    tick(); cmp("br_next_pc", pc_o, 64'h8000_0104);
    cmp("br_tag_clr", {63'd0, brch_sel_o}, 64'd0);

    // Trap and branch together: trap wins
    br_redir_i = 1'b1; br_tgt_i = 64'h8000_0300;
    trap(64'h8000_0200);
    br_redir_i = 1'b0;
    cmp("trap_pc", pc_o, 64'h8000_0200);
    tick(); cmp("trap_next_pc", pc_o, 64'h8000_0204);

    // Second redirect before target fires replaces it
    ready_i = 1'b0;
    br(64'h8000_0400);
    br(64'h8000_0500);
    cmp("rebr_pc", pc_o, 64'h8000_0500);
    cmp("rebr_tag", {63'd0, brch_sel_o}, 64'd1);
    ready_i = 1'b1;
    tick(); cmp("rebr_next", pc_o, 64'h8000_0504);

    // Misaligned target
    ready_i = 1'b0;
    br(64'h8000_0102);
    cmp("mis_pc", pc_o, ALIGN ? 64'h8000_0102 : 64'h8000_0100);
    cmp("mis_flag", {63'd0, misalign_o}, ALIGN ? 64'd1 : 64'd0);
    ready_i = 1'b1;
    tick(); cmp("mis_step_pc", pc_o, ALIGN ? 64'h8000_0106 : 64'h8000_0104);
    cmp("mis_step_flag", {63'd0, misalign_o}, ALIGN ? 64'd1 : 64'd0);
    trap(64'h8000_0600);
    cmp("mis_clear", {63'd0, misalign_o}, 64'd0);

    // Wraparound at the top of the address space
    trap(64'hFFFF_FFFF_FFFF_FFFC);
    cmp("wrap_top", pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(); cmp("wrap_zero", pc_o, 64'd0);
    tick(); cmp("wrap_four", pc_o, 64'd4);

    // Reset while a redirect tag is pending; a coincident redirect is lost
    ready_i = 1'b0;
    br(64'h8000_0700);
    cmp("pre_rst_tag", {63'd0, brch_sel_o}, 64'd1);
    reset = 1'b1; br_redir_i = 1'b1; br_tgt_i = 64'h8000_0800;
    tick();
    reset = 1'b0; br_redir_i = 1'b0;
    cmp("mid_rst_valid", {63'd0, valid_o}, 64'd0);
    cmp("mid_rst_pc", pc_o, 64'h8000_0000);
    cmp("mid_rst_tag", {63'd0, brch_sel_o}, 64'd0);

    // Redirect during boot with two wait cycles left
    tick(); tick();
    cmp("boot2_valid", {63'd0, valid_o}, 64'd0);
    br(64'h8000_0040);
    cmp("boot_br_valid", {63'd0, valid_o}, 64'd1);
    cmp("boot_br_pc", pc_o, 64'h8000_0040);
    ready_i = 1'b1;
    tick(); cmp("boot_br_next", pc_o, 64'h8000_0044);
    tick(); tick();

    cmp("no_dropped_branch", {63'd0, seen_300}, 64'd0);
    cmp("fired_count", 64'(exp_q.size()), 64'd3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Program-counter generation stage; sits directly upstream of the instruction-fetch stage in the 5-stage pipeline.
- Produces one fetch PC per valid/ready handshake.
- Steps sequentially by 4, or redirects to a branch target (from EX) or a trap target (from the CSR/WB unit).
- Tags the first beat after a redirect, so the fetch stage can pick the correct next-PC source.

Parameters:
- ADDR_W, 64, PC width in bits.
- START_ADDR, 64'h8000_0000, reset PC.
- BOOT_DELAY, 4, cycles after reset release before the first PC is offered (0 allowed).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ready_i  in  1  fetch stage can accept a PC this cycle.
- br_redir_i  in  1  branch/jump resolved taken in EX (single-cycle pulse).
- br_tgt_i  in  ADDR_W  branch target.
- trap_redir_i  in  1  trap/mret redirect (single-cycle pulse).
- trap_tgt_i  in  ADDR_W  trap or return target.
- valid_o  out  1  pc_o is a valid fetch request.
- pc_o  out  ADDR_W  fetch PC.
- brch_sel_o  out  1  current beat is the first PC after a redirect.
- misalign_o  out  1  target misaligned (see Optional Feature).

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: valid_o=0, pc_o=START_ADDR, brch_sel_o=0, misalign_o=0, boot counter=BOOT_DELAY, state=BOOT.
- States and transitions:
  - BOOT: valid_o=0; counter decrements each cycle. Go to RUN on the edge where the counter is 0. With BOOT_DELAY=0, valid_o=1 on the first cycle after reset deasserts.
  - RUN: valid_o=1.
    - fire = valid_o & ready_i.
    - On fire with no redirect: pc_o <= pc_o + 4 and brch_sel_o <= 0.
    - Without fire: pc_o, brch_sel_o and misalign_o hold.
  - Redirects are accepted in any state, including BOOT.
- Redirect handling:
  - Takes effect on the next edge regardless of ready_i; the un-accepted current PC is discarded.
  - Register updates: pc_o <= target, brch_sel_o <= 1, state <= RUN, counter cleared.
  - A redirect during BOOT ends the boot delay immediately.
- Priority: trap_redir_i beats br_redir_i when both are asserted in the same cycle. The branch target is dropped, never queued.
- Redirect in the same cycle as fire: the redirect wins; pc_o becomes the target, not pc_o + 4.
- brch_sel_o stays 1 until the target beat fires, then clears.
  - A second redirect before that fire replaces the target; brch_sel_o stays 1.
- Arithmetic: pc_o + 4 wraps modulo 2^ADDR_W with no flag; 64'hFFFF_FFFF_FFFF_FFFC steps to 0.
- Reset asserted mid-operation: next edge returns to the reset values and any pending redirect is lost.
- Latency: redirect pulse to target on pc_o = 1 cycle. Fire to next sequential PC = 1 cycle. Sustained throughput = one PC per cycle while ready_i=1.

Optional Feature:
- Macro: PC_ALIGN_CHK_EN.
- Defined:
  - A redirect target with target[1:0] != 0 is presented unmodified, with misalign_o=1 on that beat.
  - misalign_o clears on the fire of that beat, unless the new pc_o is also misaligned.
  - Sequential steps from a misaligned PC keep misalign_o=1.
- Undefined:
  - Target bits [1:0] are forced to 0 on load.
  - misalign_o is tied to 0.

Decomposition:
- Shared package/define file holds: ADDR bus width, START_ADDR, the instruction step constant 4, and the state encoding (BOOT=2'd0, RUN=2'd1).
- One sub-module is natural: pc_redir_arb, the combinational trap-over-branch priority select producing redir and redir_tgt.
- The boot counter and PC register stay in the top block.

Test Plan:
- Reset, BOOT_DELAY=4, ready_i=1 throughout -> valid_o=0 for 4 cycles after reset falls, then pc_o = 0x80000000, 0x80000004, 0x80000008 on consecutive cycles.
- ready_i=0 for 3 cycles at pc 0x80000008 -> pc_o and valid_o held; ready_i=1 -> next cycle pc_o=0x8000000C.
- br_redir_i pulse with br_tgt_i=0x80000100 while ready_i=0 -> next cycle pc_o=0x80000100, brch_sel_o=1 until fire, then pc_o=0x80000104, brch_sel_o=0.
- trap_redir_i (0x80000200) and br_redir_i (0x80000300) in the same cycle -> pc_o=0x80000200 and 0x80000300 never appears.
- Redirect (0x80000040) during BOOT with counter=2 -> valid_o=1, pc_o=0x80000040 on the next cycle.
- br_tgt_i=0x80000102 with PC_ALIGN_CHK_EN -> pc_o=0x80000102, misalign_o=1. Without the macro -> pc_o=0x80000100, misalign_o=0.
- Reset asserted while brch_sel_o=1 -> next cycle valid_o=0, pc_o=0x80000000, brch_sel_o=0.
